// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared pc_src encodings, FSM state type and default handler address
package fetch_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_EXC    = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_EXC_ADDR = 32'h00FF00FF;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular fetch queue holding {bundle, pc_next} entries
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     enq_i,
    input  logic [WIDTH-1:0]         enq_data_i,
    input  logic                     deq_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_enq;
    logic             do_deq;

    // A dequeue frees a slot in the same cycle, so a full queue may still accept.
    assign do_deq      = deq_i && (count_q != '0);
    assign do_enq      = enq_i && ((count_q != FULL) || do_deq);
    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    // Entry storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_enq && !clear_i) begin
            mem_q[wr_ptr_q] <= enq_data_i;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_deq) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_enq, do_deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vliw_fetch_unit.sv
// rtl/vliw_fetch_unit.sv - VLIW bundle fetch FSM with fetch queue; FETCH_STATS_EN adds bubble counter
module vliw_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                SLOTS    = 2,
    parameter int                SLOT_W   = 16,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] EXC_ADDR = ADDR_W'(DEFAULT_EXC_ADDR)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pc_write,
    input  logic [1:0]                pc_src,
    input  logic [ADDR_W-1:0]         pc_branch_target,
    input  logic [ADDR_W-1:0]         pc_jump_target,
    input  logic                      flush,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [ADDR_W-1:0]         imem_req_addr,
    input  logic                      imem_resp_valid,
    input  logic [SLOTS*SLOT_W-1:0]   imem_resp_data,
    output logic                      deq_valid,
    input  logic                      deq_ready,
    output logic [SLOTS*SLOT_W-1:0]   deq_bundle,
    output logic [ADDR_W-1:0]         deq_pc_next,
    output logic [31:0]               fetch_bubbles
);

    localparam int                BUNDLE_W = SLOTS * SLOT_W;
    localparam int                ENTRY_W  = BUNDLE_W + ADDR_W;
    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] BSTEP    = ADDR_W'(BUNDLE_W / 8);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              active_q;
    logic              redirect;
    logic              kill;
    logic              req_fire;
    logic              enq;
    logic              deq;
    logic [CNT_W-1:0]  count;
    logic [ENTRY_W-1:0] head;

    assign redirect       = (pc_src != PC_SEQ);
    assign kill           = redirect || flush;
    // active_q keeps the request line low while reset is held and for the first cycle after.
    assign imem_req_valid = active_q && (state_q == IDLE) && pc_write && !kill && (count < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign deq_valid      = (count != '0);
    assign deq            = deq_valid && deq_ready && !kill;
    assign deq_bundle     = head[ENTRY_W-1 -: BUNDLE_W];
    assign deq_pc_next    = head[ADDR_W-1:0];

    // Next state: one request outstanding at a time; a redirect or flush turns the wait into a discard.
    always_comb begin
        state_d = state_q;
        enq     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (kill) begin
                    state_d = imem_resp_valid ? IDLE : DISCARD;
                end else if (imem_resp_valid) begin
                    state_d = IDLE;
                    enq     = 1'b1;
                end
            end
            DISCARD: begin
                if (imem_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next fetch PC: redirect targets win, otherwise advance on an accepted request.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        case (pc_src_e'(pc_src))
            PC_BRANCH: fetch_pc_d = pc_branch_target;
            PC_JUMP:   fetch_pc_d = pc_jump_target;
            PC_EXC:    fetch_pc_d = EXC_ADDR;
            default: begin
                if (req_fire) begin
                    fetch_pc_d = fetch_pc_q + BSTEP;
                end
            end
        endcase
    end

    // State, fetch PC and request-enable registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            active_q   <= 1'b1;
        end
    end

    // fetch_pc_q already holds request PC + BSTEP while waiting, which is the bundle's pc_next.
    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (kill),
        .enq_i       (enq),
        .enq_data_i  ({imem_resp_data, fetch_pc_q}),
        .deq_i       (deq),
        .head_data_o (head),
        .count_o     (count)
    );

`ifdef FETCH_STATS_EN
    logic [31:0] bubbles_q;

    // Count decode cycles that wanted a bundle but found the queue empty; saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubbles_q <= '0;
        end else if (deq_ready && !deq_valid && (bubbles_q != '1)) begin
            bubbles_q <= bubbles_q + 32'd1;
        end
    end

    assign fetch_bubbles = bubbles_q;
`else
    assign fetch_bubbles = 32'd0;
`endif

endmodule

// File: tb/tb_vliw_fetch_unit.sv
// tb/tb_vliw_fetch_unit.sv - scoreboard bench for vliw_fetch_unit
module tb_vliw_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [31:0] pc_branch_target;
    logic [31:0] pc_jump_target;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_bundle;
    logic [31:0] deq_pc_next;
    logic [31:0] fetch_bubbles;

`ifdef FETCH_STATS_EN
    localparam logic [31:0] EXP_BUBBLES = 32'd5;
`else
    localparam logic [31:0] EXP_BUBBLES = 32'd0;
`endif
    localparam logic [31:0] EXC_PC = 32'h00FF00FF;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_deq = 0;
    int          lat   = 1;
    logic [63:0] sb [$];
    logic [31:0] exp_req_addr = 32'd0;

    always #5 clk = ~clk;

    vliw_fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .pc_write         (pc_write),
        .pc_src           (pc_src),
        .pc_branch_target (pc_branch_target),
        .pc_jump_target   (pc_jump_target),
        .flush            (flush),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .deq_valid        (deq_valid),
        .deq_ready        (deq_ready),
        .deq_bundle       (deq_bundle),
        .deq_pc_next      (deq_pc_next),
        .fetch_bubbles    (fetch_bubbles)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_data(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns at posedge+1 of the cycle after a request was accepted (DUT waiting).
    task automatic wait_accept();
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) got = 1'b1;
        end
        check("accept_seen", 64'(got), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Memory model: checks request order, pushes expected entry, responds after lat cycles.
    initial begin
        logic        pend = 1'b0;
        int          cnt  = 0;
        logic [31:0] paddr = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            imem_resp_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mk_data(paddr);
                    pend = 1'b0;
                end
            end
            if (imem_req_valid && imem_req_ready && !reset) begin
                check("req_addr", 64'(imem_req_addr), 64'(exp_req_addr));
                sb.push_back({mk_data(exp_req_addr), exp_req_addr + 32'd4});
                exp_req_addr = exp_req_addr + 32'd4;
                pend  = 1'b1;
                cnt   = lat;
                paddr = imem_req_addr;
            end
        end
    end

    // Dequeue checker: compares the head against the oldest expected entry.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!reset && deq_valid && deq_ready && pc_src == 2'd0 && !flush) begin
                if (sb.size() == 0) begin
                    check("deq_unexpected", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("deq_bundle", 64'(deq_bundle), 64'(e[63:32]));
                    check("deq_pc_next", 64'(deq_pc_next), 64'(e[31:0]));
                    n_deq++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset            = 1'b1;
        pc_write         = 1'b0;
        pc_src           = 2'd0;
        pc_branch_target = '0;
        pc_jump_target   = '0;
        flush            = 1'b0;
        imem_req_ready   = 1'b1;
        deq_ready        = 1'b0;
        #12;
        check("rst_deq_valid", 64'(deq_valid), 64'd0);
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_req_addr", 64'(imem_req_addr), 64'd0);
        check("rst_deq_bundle", 64'(deq_bundle), 64'd0);
        check("rst_deq_pc_next", 64'(deq_pc_next), 64'd0);
        check("rst_bubbles", 64'(fetch_bubbles), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Five starved cycles
        deq_ready = 1'b1;
        step(5);
        deq_ready = 1'b0;
        check("bubbles_5", 64'(fetch_bubbles), 64'(EXP_BUBBLES));

        // Sequential streaming
        deq_ready = 1'b1;
        pc_write  = 1'b1;
        step(20);
        pc_write = 1'b0;
        step(6);
        check("stream_drained", 64'(sb.size()), 64'd0);
        check("stream_progress", 64'(n_deq >= 8), 64'd1);

        // Backpressure from decode: queue fills to DEPTH
        deq_ready = 1'b0;
        pc_write  = 1'b1;
        step(20);
        check("full_entries", 64'(sb.size()), 64'd4);
        check("full_deq_valid", 64'(deq_valid), 64'd1);
        check("full_req_valid", 64'(imem_req_valid), 64'd0);
        pc_write  = 1'b0;
        deq_ready = 1'b1;
        step(8);
        check("full_drained", 64'(sb.size()), 64'd0);
        check("full_empty", 64'(deq_valid), 64'd0);

        // Memory not ready: request held stable
        imem_req_ready = 1'b0;
        pc_write       = 1'b1;
        step(3);
        check("hold_req_valid", 64'(imem_req_valid), 64'd1);
        check("hold_req_addr", 64'(imem_req_addr), 64'(exp_req_addr));
        imem_req_ready = 1'b1;
        step(6);

        // Branch while waiting, two-cycle memory: stale response discarded
        lat = 2;
        wait_accept();
        pc_src           = 2'd1;
        pc_branch_target = 32'h100;
        sb.delete();
        exp_req_addr = 32'h100;
        step(1);
        pc_src = 2'd0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (deq_valid) seen = 1'b1;
        end
        check("branch_deq_seen", 64'(seen), 64'd1);
        check("branch_first_pc_next", 64'(deq_pc_next), 64'h104);
        step(8);
        lat = 1;

        // Exception with a partly filled queue
        deq_ready = 1'b0;
        step(10);
        check("exc_pre_valid", 64'(deq_valid), 64'd1);
        pc_src = 2'd3;
        sb.delete();
        exp_req_addr = EXC_PC;
        step(1);
        pc_src = 2'd0;
        check("exc_queue_empty", 64'(deq_valid), 64'd0);
        deq_ready = 1'b1;
        step(10);

        // Jump near the top of the address space: PC wraps to 0
        pc_src         = 2'd2;
        pc_jump_target = 32'hFFFF_FFFC;
        sb.delete();
        exp_req_addr = 32'hFFFF_FFFC;
        step(1);
        pc_src = 2'd0;
        step(12);

        // Flush keeps fetch_pc, empties the queue
        deq_ready = 1'b0;
        step(8);
        flush = 1'b1;
        sb.delete();
        step(1);
        flush = 1'b0;
        check("flush_empty", 64'(deq_valid), 64'd0);
        deq_ready = 1'b1;
        step(10);

        // Reset while a request is outstanding
        wait_accept();
        reset = 1'b1;
        sb.delete();
        exp_req_addr = 32'd0;
        step(2);
        check("midrst_deq_valid", 64'(deq_valid), 64'd0);
        check("midrst_req_valid", 64'(imem_req_valid), 64'd0);
        reset = 1'b0;
        step(10);
        pc_write = 1'b0;
        step(6);
        check("final_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
